multicycle_ctrl_fsm: RTL and testbench

- Main control FSM for the multi-cycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the PC write enable, IR write enable, memory request and mux selects.
- Sits between the instruction register/ALU flags and the datapath. Handles a memory ready handshake with a bounded wait timeout.

---
 rtl/multicycle_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional retired-instruction counter is enabled by defining MULTICYCLE_CTRL_INSTRET_EN.
module multicycle_ctrl_fsm #(
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        adr_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic        illegal,
    output logic        bus_err,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_WB_MEM    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_WB_ALU    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JALR_ADDR = 4'd10,
        S_JUMP      = 4'd11,
        S_LUI       = 4'd12,
        S_AUIPC     = 4'd13,
        S_ILLEGAL   = 4'd14,
        S_BUS_ERR   = 4'd15
    } state_t;

    localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);
    localparam bit TIMEOUT_EN = (MEM_WAIT_MAX > 0);

    state_t           state_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             waiting;
    logic             timeout;

    assign waiting      = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign wait_cnt_inc = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;
    // mem_ready on the last allowed cycle still completes the request normally.
    assign timeout      = TIMEOUT_EN && waiting && !mem_ready && (wait_cnt == WAIT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            if (timeout) begin
                state_q <= S_BUS_ERR;
            end else begin
                case (state_q)
                    S_FETCH: begin
                        if (mem_ready) state_q <= S_DECODE;
                        else           wait_cnt <= wait_cnt_inc;
                    end
                    S_DECODE: begin
                        case (opcode)
                            7'b0000011, 7'b0100011: state_q <= S_MEM_ADDR;
                            7'b0110011:             state_q <= S_EXEC_R;
                            7'b0010011:             state_q <= S_EXEC_I;
                            7'b1100011:             state_q <= S_BRANCH;
                            7'b1101111:             state_q <= S_JUMP;
                            7'b1100111:             state_q <= S_JALR_ADDR;
                            7'b0110111:             state_q <= S_LUI;
                            7'b0010111:             state_q <= S_AUIPC;
                            default:                state_q <= S_ILLEGAL;
                        endcase
                    end
                    S_MEM_ADDR:  state_q <= opcode[5] ? S_MEM_WR : S_MEM_RD;
                    S_MEM_RD: begin
                        if (mem_ready) state_q <= S_WB_MEM;
                        else           wait_cnt <= wait_cnt_inc;
                    end
                    S_WB_MEM:    state_q <= S_FETCH;
                    S_MEM_WR: begin
                        if (mem_ready) state_q <= S_FETCH;
                        else           wait_cnt <= wait_cnt_inc;
                    end
                    S_EXEC_R:    state_q <= S_WB_ALU;
                    S_EXEC_I:    state_q <= S_WB_ALU;
                    S_WB_ALU:    state_q <= S_FETCH;
                    S_BRANCH:    state_q <= S_FETCH;
                    S_JALR_ADDR: state_q <= S_JUMP;
                    S_JUMP:      state_q <= S_WB_ALU;
                    S_LUI:       state_q <= S_WB_ALU;
                    S_AUIPC:     state_q <= S_WB_ALU;
                    S_ILLEGAL:   state_q <= S_ILLEGAL;
                    S_BUS_ERR:   state_q <= S_BUS_ERR;
                endcase
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        result_src = 2'd0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_WB_MEM: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'd2;
                alu_op    = 2'd2;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                alu_op    = 2'd2;
            end
            S_WB_ALU:  reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'd2;
                alu_op    = 2'd1;
                pc_write  = branch_taken;
            end
            S_JALR_ADDR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
            end
            S_JUMP: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                pc_write  = 1'b1;
            end
            S_LUI: begin
                alu_src_a = 2'd3;
                alu_src_b = 2'd1;
            end
            S_AUIPC: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
            end
            S_ILLEGAL: illegal = 1'b1;
            S_BUS_ERR: bus_err = 1'b1;
        endcase
        // Reset is asynchronous, so outputs must be silenced before the next edge.
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            adr_src    = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 2'd0;
            alu_src_b  = 2'd0;
            alu_op     = 2'd0;
            result_src = 2'd0;
            illegal    = 1'b0;
            bus_err    = 1'b0;
        end
    end

    assign state = state_q;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic        retire;
    logic [31:0] instret_q;

    assign retire = (state_q == S_WB_MEM) || (state_q == S_WB_ALU) || (state_q == S_BRANCH)
                 || ((state_q == S_MEM_WR) && mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         instret_q <= '0;
        else if (retire) instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: table-driven instruction walk on an unbounded-wait
// instance plus a MEM_WAIT_MAX=4 instance for timeout, illegal-opcode and reset corner cases.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       adr_src;
        logic       mem_req;
        logic       mem_we;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       illegal;
        logic       bus_err;
    } ctrl_t;

    typedef struct {
        logic [6:0] opcode;
        logic       mem_ready;
        logic       branch_taken;
        logic [3:0] state;
        ctrl_t      ctrl;
    } vec_t;

    localparam logic [6:0] OP_ADD   = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;

    logic        a_pc_write, a_ir_write, a_adr_src, a_mem_req, a_mem_we, a_reg_write;
    logic [1:0]  a_alu_src_a, a_alu_src_b, a_alu_op, a_result_src;
    logic        a_illegal, a_bus_err;
    logic [3:0]  a_state;
    logic [31:0] a_instret;

    logic        b_pc_write, b_ir_write, b_adr_src, b_mem_req, b_mem_we, b_reg_write;
    logic [1:0]  b_alu_src_a, b_alu_src_b, b_alu_op, b_result_src;
    logic        b_illegal, b_bus_err;
    logic [3:0]  b_state;
    logic [31:0] b_instret;

    ctrl_t a_ctrl, b_ctrl;
    int    checks = 0;
    int    errors = 0;
    vec_t  vecs[$];

    always #5 clk = ~clk;

    multicycle_ctrl_fsm dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .pc_write(a_pc_write), .ir_write(a_ir_write), .adr_src(a_adr_src), .mem_req(a_mem_req),
        .mem_we(a_mem_we), .reg_write(a_reg_write), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .alu_op(a_alu_op), .result_src(a_result_src), .illegal(a_illegal), .bus_err(a_bus_err),
        .state(a_state), .instret(a_instret)
    );

    multicycle_ctrl_fsm #(.MEM_WAIT_MAX(4)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .ir_write(b_ir_write), .adr_src(b_adr_src), .mem_req(b_mem_req),
        .mem_we(b_mem_we), .reg_write(b_reg_write), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .alu_op(b_alu_op), .result_src(b_result_src), .illegal(b_illegal), .bus_err(b_bus_err),
        .state(b_state), .instret(b_instret)
    );

    assign a_ctrl = {a_pc_write, a_ir_write, a_adr_src, a_mem_req, a_mem_we, a_reg_write,
                     a_alu_src_a, a_alu_src_b, a_alu_op, a_result_src, a_illegal, a_bus_err};
    assign b_ctrl = {b_pc_write, b_ir_write, b_adr_src, b_mem_req, b_mem_we, b_reg_write,
                     b_alu_src_a, b_alu_src_b, b_alu_op, b_result_src, b_illegal, b_bus_err};

    function automatic ctrl_t mk(input int pcw, input int irw, input int adr, input int req,
                                 input int we, input int rw, input int a, input int b,
                                 input int op, input int rs, input int ill, input int be);
        ctrl_t c;
        c.pc_write   = pcw[0];
        c.ir_write   = irw[0];
        c.adr_src    = adr[0];
        c.mem_req    = req[0];
        c.mem_we     = we[0];
        c.reg_write  = rw[0];
        c.alu_src_a  = a[1:0];
        c.alu_src_b  = b[1:0];
        c.alu_op     = op[1:0];
        c.result_src = rs[1:0];
        c.illegal    = ill[0];
        c.bus_err    = be[0];
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [6:0] op, input int rdy, input int bt, input int st, input ctrl_t c);
        vec_t v;
        v.opcode       = op;
        v.mem_ready    = rdy[0];
        v.branch_taken = bt[0];
        v.state        = st[3:0];
        v.ctrl         = c;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        ctrl_t e_f_rdy, e_f_wait, e_dec, e_maddr, e_mrd, e_wbm, e_mwr, e_exr, e_exi, e_wba;
        ctrl_t e_br_t, e_br_n, e_jalr, e_jump, e_lui, e_auipc;
        logic [31:0] exp_instret;

        //              pcw irw adr req we rw  a  b  op rs ill be
        e_f_rdy  = mk(1, 1, 0, 1, 0, 0, 0, 2, 0, 2, 0, 0);
        e_f_wait = mk(0, 0, 0, 1, 0, 0, 0, 2, 0, 2, 0, 0);
        e_dec    = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        e_maddr  = mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        e_mrd    = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        e_wbm    = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        e_mwr    = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        e_exr    = mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0);
        e_exi    = mk(0, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0, 0);
        e_wba    = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        e_br_t   = mk(1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
        e_br_n   = mk(0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
        e_jalr   = mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        e_jump   = mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        e_lui    = mk(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        e_auipc  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        add(OP_ADD,   1, 0, 0,  e_f_rdy); add(OP_ADD,   0, 0, 1,  e_dec);
        add(OP_ADD,   1, 0, 6,  e_exr);   add(OP_ADD,   0, 0, 8,  e_wba);
        add(OP_ADDI,  0, 0, 0,  e_f_wait); add(OP_ADDI, 1, 0, 0,  e_f_rdy);
        add(OP_ADDI,  1, 1, 1,  e_dec);   add(OP_ADDI,  0, 0, 7,  e_exi);
        add(OP_ADDI,  1, 0, 8,  e_wba);
        add(OP_LUI,   1, 0, 0,  e_f_rdy); add(OP_LUI,   0, 0, 1,  e_dec);
        add(OP_LUI,   0, 0, 12, e_lui);   add(OP_LUI,   0, 0, 8,  e_wba);
        add(OP_AUIPC, 1, 0, 0,  e_f_rdy); add(OP_AUIPC, 0, 0, 1,  e_dec);
        add(OP_AUIPC, 0, 0, 13, e_auipc); add(OP_AUIPC, 0, 0, 8,  e_wba);
        add(OP_LD,    1, 0, 0,  e_f_rdy); add(OP_LD,    1, 0, 1,  e_dec);
        add(OP_LD,    1, 0, 2,  e_maddr); add(OP_LD,    0, 0, 3,  e_mrd);
        add(OP_LD,    0, 0, 3,  e_mrd);   add(OP_LD,    0, 0, 3,  e_mrd);
        add(OP_LD,    1, 0, 3,  e_mrd);   add(OP_LD,    0, 0, 4,  e_wbm);
        add(OP_ST,    1, 0, 0,  e_f_rdy); add(OP_ST,    0, 0, 1,  e_dec);
        add(OP_ST,    0, 0, 2,  e_maddr); add(OP_ST,    0, 0, 5,  e_mwr);
        add(OP_ST,    1, 0, 5,  e_mwr);
        add(OP_BR,    1, 0, 0,  e_f_rdy); add(OP_BR,    0, 1, 1,  e_dec);
        add(OP_BR,    0, 1, 9,  e_br_t);
        add(OP_BR,    1, 1, 0,  e_f_rdy); add(OP_BR,    0, 0, 1,  e_dec);
        add(OP_BR,    0, 0, 9,  e_br_n);
        add(OP_JAL,   1, 0, 0,  e_f_rdy); add(OP_JAL,   0, 0, 1,  e_dec);
        add(OP_JAL,   0, 0, 11, e_jump);  add(OP_JAL,   0, 0, 8,  e_wba);
        add(OP_JALR,  1, 0, 0,  e_f_rdy); add(OP_JALR,  0, 0, 1,  e_dec);
        add(OP_JALR,  0, 0, 10, e_jalr);  add(OP_JALR,  0, 0, 11, e_jump);
        add(OP_JALR,  0, 0, 8,  e_wba);   add(OP_JALR,  0, 0, 0,  e_f_wait);

        // Reset: FETCH would request memory, but every output must read 0 while rst is high.
        rst = 1'b1; opcode = OP_ADD; branch_taken = 1'b1; mem_ready = 1'b1;
        #2;
        check("reset state_a", 32'(a_state), 32'd0);
        check("reset ctrl_a", 32'(a_ctrl), 32'd0);
        check("reset ctrl_b", 32'(b_ctrl), 32'd0);
        check("reset instret_a", a_instret, 32'd0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            opcode       = vecs[i].opcode;
            mem_ready    = vecs[i].mem_ready;
            branch_taken = vecs[i].branch_taken;
            #1;
            check($sformatf("vec%0d state_a", i), 32'(a_state), 32'(vecs[i].state));
            check($sformatf("vec%0d ctrl_a", i), 32'(a_ctrl), 32'(vecs[i].ctrl));
            check($sformatf("vec%0d state_b", i), 32'(b_state), 32'(vecs[i].state));
            check($sformatf("vec%0d ctrl_b", i), 32'(b_ctrl), 32'(vecs[i].ctrl));
            tick();
        end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
        exp_instret = 32'd10;
`else
        exp_instret = 32'd0;
`endif
        check("instret_a after table", a_instret, exp_instret);
        check("instret_b after table", b_instret, exp_instret);

        // Undefined opcode: terminal ILLEGAL, no requests even with mem_ready high.
        pulse_reset();
        opcode = 7'b0000000; mem_ready = 1'b1; branch_taken = 1'b0;
        tick();
        tick();
        check("illegal entry state", 32'(a_state), 32'd14);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("illegal hold %0d", i), {27'd0, a_state, a_illegal}, {27'd0, 4'd14, 1'b1});
            check($sformatf("illegal no req %0d", i), 32'(a_mem_req), 32'd0);
        end
        check("illegal instret", a_instret, 32'd0);
        rst = 1'b1;
        #1;
        check("illegal cleared state", 32'(a_state), 32'd0);
        check("illegal cleared flag", 32'(a_illegal), 32'd0);
        tick();
        rst = 1'b0;

        // Store with no mem_ready: bounded instance times out, unbounded one keeps waiting.
        opcode = OP_ST; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        check("store enter a", 32'(a_state), 32'd5);
        check("store enter b", 32'(b_state), 32'd5);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("store wait b %0d", k), {28'd0, b_state}, 32'd5);
            check($sformatf("store we stable b %0d", k), {30'd0, b_mem_we, b_mem_req}, 32'd3);
        end
        tick();
        check("bus_err state b", 32'(b_state), 32'd15);
        check("bus_err flag b", {30'd0, b_bus_err, b_mem_req}, 32'd2);
        check("unbounded still waiting a", 32'(a_state), 32'd5);
        repeat (16) tick();
        check("unbounded long wait a", {26'd0, a_state, a_mem_req, a_mem_we}, {26'd0, 4'd5, 2'b11});
        check("bus_err sticky b", {27'd0, b_state, b_bus_err}, {27'd0, 4'd15, 1'b1});

        // Reset in the middle of a write: strobe drops immediately.
        rst = 1'b1;
        #1;
        check("mid-write reset we_a", {30'd0, a_mem_we, a_mem_req}, 32'd0);
        check("mid-write reset state_a", 32'(a_state), 32'd0);
        check("mid-write reset bus_err_b", 32'(b_bus_err), 32'd0);
        tick();
        rst = 1'b0;

        // mem_ready on the last allowed wait cycle completes the store instead of timing out.
        opcode = OP_ST; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        tick();
        tick();
        tick();
        mem_ready = 1'b1;
        #1;
        check("ready-wins pre state_b", 32'(b_state), 32'd5);
        tick();
        check("ready-wins state_b", 32'(b_state), 32'd0);
        check("ready-wins bus_err_b", 32'(b_bus_err), 32'd0);

        // Fetch timeout on the bounded instance.
        mem_ready = 1'b0;
        tick();
        tick();
        tick();
        check("fetch wait b", 32'(b_state), 32'd0);
        tick();
        check("fetch timeout b", 32'(b_state), 32'd15);
        check("fetch unbounded a", 32'(a_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
